// File: rtl/imem_dmem_port_arbiter.sv
// Shares one single-port synchronous RAM between the fetch port and the load/store port.
// Data wins ties; fetch is guaranteed a slot after STARVE_MAX consecutive data grants.
module imem_dmem_port_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // state   | meaning
    // RD_NONE | no read data returning this cycle
    // RD_IF   | mem_rdata belongs to the fetch port
    // RD_D    | mem_rdata belongs to the load port
    typedef enum logic [1:0] {RD_NONE, RD_IF, RD_D} rd_owner_t;

    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    rd_owner_t  rd_owner, rd_owner_nxt;
    logic [3:0] starve_cnt, starve_cnt_nxt;
    logic       take_d, take_if;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            rd_owner   <= RD_NONE;
            starve_cnt <= 4'd0;
        end else begin
            rd_owner   <= rd_owner_nxt;
            starve_cnt <= starve_cnt_nxt;
        end
    end

    always_comb begin
        take_d         = 1'b0;
        take_if        = 1'b0;
        rd_owner_nxt   = RD_NONE;
        starve_cnt_nxt = starve_cnt;

        // Grants are gated by RSTn so nothing reaches the RAM while in reset.
        if (RSTn) begin
            take_d  = d_req && !(if_req && (starve_cnt == SMAX));
            take_if = if_req && !take_d;
        end

        if (take_if)
            rd_owner_nxt = RD_IF;
        else if (take_d && !d_we)
            rd_owner_nxt = RD_D;

        if (take_if || !if_req)
            starve_cnt_nxt = 4'd0;
        else if (take_d && (starve_cnt < SMAX))
            starve_cnt_nxt = starve_cnt + 4'd1;
    end

    assign if_gnt    = take_if;
    assign d_gnt     = take_d;
    assign mem_en    = take_d | take_if;
    assign mem_we    = take_d & d_we;
    assign mem_addr  = take_d ? d_addr : (take_if ? if_addr : '0);
    assign mem_wdata = mem_en ? d_wdata : '0;

    assign if_rvalid = (rd_owner == RD_IF);
    assign d_rvalid  = (rd_owner == RD_D);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rdata   = d_rvalid  ? mem_rdata : '0;

endmodule
